// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered UART transmitter, 8N1 or 8E1 framing.
// Bytes are queued through a valid/ready push port and serialized LSB first
// on a registered, idle-high TX line. Back-to-back frames have no idle gap.
module uart_tx_ctrl #(
    parameter int CLK_FREQ     = 8000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int PARITY_EN    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk_in,
    input  logic                               reset,
    input  logic [7:0]                         data_in,
    input  logic                               valid_in,
    output logic                               ready_out,
    input  logic                               tx_enable,
    output logic                               uart_tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // The queue is kept in flops so the head byte is available on the pop edge.
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          push;
    logic          pop;
    logic          can_start;
    logic          baud_last;
    logic [7:0]    head;

    assign ready_out  = (level_q != LW'(FIFO_DEPTH));
    assign push       = valid_in && ready_out;
    assign head       = mem_q[rd_ptr_q];
    assign can_start  = (level_q != '0) && tx_enable;
    assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));

    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

    // FIFO next state: write on push, advance read pointer on pop, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: each state lasts CLKS_PER_BIT cycles; tx_d is the line value for the next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = ^head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (can_start) begin
                        // Next frame starts immediately: no idle cycle after the stop bit.
                        pop     = 1'b1;
                        shift_d = head;
                        par_d   = ^head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers; active-low reset aborts any frame and discards the queue.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with a UART receiver model.
// dut0 is the 8N1 instance, dut1 the 8E1 instance; they share clock and reset.
module tb_uart_tx_ctrl;

    localparam int CPB = 69;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data0, data1;
    logic       valid0, valid1, en0, en1;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;
    logic [2:0] level0, level1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bad0   = 0;
    int bad1   = 0;

    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    int         rxs0[$];
    int         rxs1[$];
    logic       rxp1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_ctrl #(.CLK_FREQ(8000000), .BAUD_RATE(115200), .PARITY_EN(0), .FIFO_DEPTH(4)) dut0 (
        .clk_in(clk), .reset(rst_n), .data_in(data0), .valid_in(valid0), .ready_out(ready0),
        .tx_enable(en0), .uart_tx(tx0), .busy(busy0), .fifo_level(level0)
    );

    uart_tx_ctrl #(.CLK_FREQ(8000000), .BAUD_RATE(115200), .PARITY_EN(1), .FIFO_DEPTH(4)) dut1 (
        .clk_in(clk), .reset(rst_n), .data_in(data1), .valid_in(valid1), .ready_out(ready1),
        .tx_enable(en1), .uart_tx(tx1), .busy(busy1), .fifo_level(level1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input bit par);
        return par ? tx1 : tx0;
    endfunction

    function automatic logic busy_of(input bit par);
        return par ? busy1 : busy0;
    endfunction

    // Receiver model: start detect, mid-bit sampling, records byte, parity and start cycle.
    task automatic rx_loop(input bit par);
        logic [7:0] b;
        logic       p;
        int         st;
        forever begin
            @(negedge clk);
            if (line_of(par) === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (line_of(par) === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = line_of(par);
                    end
                    p = 1'b0;
                    if (par) begin
                        repeat (CPB) @(negedge clk);
                        p = line_of(par);
                    end
                    repeat (CPB) @(negedge clk);
                    if (par) begin
                        rxq1.push_back(b); rxs1.push_back(st); rxp1.push_back(p);
                        if (line_of(par) !== 1'b1) bad1++;
                    end else begin
                        rxq0.push_back(b); rxs0.push_back(st);
                        if (line_of(par) !== 1'b1) bad0++;
                    end
                end
            end
        end
    endtask

    initial rx_loop(1'b0);
    initial rx_loop(1'b1);

    task automatic rx_expect(input string tag, input bit par, input int idx, input logic [7:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (!par && idx < rxq0.size()) obs = {24'd0, rxq0[idx]};
        if (par && idx < rxq1.size())  obs = {24'd0, rxq1[idx]};
        check(tag, obs, {24'd0, exp});
    endtask

    task automatic wait_idle(input string tag, input bit par, input int max);
        int n;
        n = 0;
        while (busy_of(par) === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy_of(par)}, 32'd0);
    endtask

    task automatic wait_rx0(input string tag, input int cnt, input int max);
        int n;
        n = 0;
        while (rxq0.size() < cnt && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, rxq0.size(), cnt);
    endtask

    initial begin
        logic [7:0] b;
        logic       seg_ok, bsy_ok, exp_bit, hold_ok;
        int         cnt;

        rst_n = 1'b0; data0 = '0; data1 = '0; valid0 = 1'b0; valid1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_level", {29'd0, level0}, 32'd0);
        check("rst_ready", {31'd0, ready0}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55, 8N1.
        data0 = 8'h55; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        check("t1_tx_before_start", {31'd0, tx0}, 32'd1);
        check("t1_level_after_push", {29'd0, level0}, 32'd1);
        @(negedge clk);
        b = 8'h55;
        bsy_ok = 1'b1;
        for (int s = 0; s < 10; s++) begin
            seg_ok = 1'b1;
            exp_bit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
            for (int c = 0; c < CPB; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                if (tx0 !== exp_bit) seg_ok = 1'b0;
                if (busy0 !== 1'b1) bsy_ok = 1'b0;
            end
            check($sformatf("t1_seg%0d", s), {31'd0, seg_ok}, 32'd1);
        end
        @(negedge clk);
        check("t1_busy_690", {31'd0, bsy_ok}, 32'd1);
        check("t1_busy_end", {31'd0, busy0}, 32'd0);
        check("t1_tx_idle", {31'd0, tx0}, 32'd1);
        check("t1_rx_count", rxq0.size(), 32'd1);
        rx_expect("t1_rx_byte", 1'b0, 0, 8'h55);

        // Parity frames on dut1: 0xA5 (parity 0), 0x07 (parity 1), back to back.
        @(negedge clk);
        data1 = 8'hA5; valid1 = 1'b1;
        @(negedge clk);
        data1 = 8'h07;
        @(negedge clk);
        valid1 = 1'b0;
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_busy_cycles", cnt, 32'd1518);
        rx_expect("t2_rx_byte0", 1'b1, 0, 8'hA5);
        rx_expect("t2_rx_byte1", 1'b1, 1, 8'h07);
        check("t2_parity0", (rxp1.size() > 0) ? {31'd0, rxp1[0]} : 32'hx, 32'd0);
        check("t2_parity1", (rxp1.size() > 1) ? {31'd0, rxp1[1]} : 32'hx, 32'd1);
        check("t2_frame_len", (rxs1.size() > 1) ? rxs1[1] - rxs1[0] : -1, 32'd759);

        // FIFO full, stalled fifth byte, back-to-back drain.
        rxq0.delete(); rxs0.delete();
        en0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            data0 = 8'(i); valid0 = 1'b1;
        end
        @(negedge clk);
        data0 = 8'h05;
        check("t3_level_full", {29'd0, level0}, 32'd4);
        check("t3_ready_full", {31'd0, ready0}, 32'd0);
        repeat (5) @(negedge clk);
        check("t3_stalled_level", {29'd0, level0}, 32'd4);
        en0 = 1'b1;
        @(negedge clk);
        check("t3_ready_after_pop", {31'd0, ready0}, 32'd1);
        check("t3_level_after_pop", {29'd0, level0}, 32'd3);
        check("t3_tx_start", {31'd0, tx0}, 32'd0);
        @(negedge clk);
        valid0 = 1'b0;
        check("t3_level_refill", {29'd0, level0}, 32'd4);
        wait_rx0("t3_rx_count", 5, 5000);
        for (int i = 0; i < 5; i++) rx_expect($sformatf("t3_rx_byte%0d", i), 1'b0, i, 8'(i + 1));
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_gap%0d", i), (rxs0.size() > i + 1) ? rxs0[i+1] - rxs0[i] : -1, 32'd690);
        wait_idle("t3_idle_timeout", 1'b0, 1000);

        // Enable gating mid-frame.
        rxq0.delete(); rxs0.delete();
        @(negedge clk);
        data0 = 8'h3C; valid0 = 1'b1;
        @(negedge clk);
        data0 = 8'hC3;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (200) @(negedge clk);
        en0 = 1'b0;
        wait_idle("t4_idle_timeout", 1'b0, 1000);
        check("t4_tx_high", {31'd0, tx0}, 32'd1);
        check("t4_level", {29'd0, level0}, 32'd1);
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || level0 !== 3'd1) hold_ok = 1'b0;
        end
        check("t4_hold_idle", {31'd0, hold_ok}, 32'd1);
        rx_expect("t4_rx_3c", 1'b0, 0, 8'h3C);
        en0 = 1'b1;
        @(negedge clk);
        check("t4_restart_tx", {31'd0, tx0}, 32'd0);
        check("t4_restart_busy", {31'd0, busy0}, 32'd1);
        wait_idle("t4_idle2_timeout", 1'b0, 1000);
        rx_expect("t4_rx_c3", 1'b0, 1, 8'hC3);

        // Reset during DATA bit 3 of 0xF0 with two bytes queued.
        @(negedge clk);
        data0 = 8'hF0; valid0 = 1'b1;
        @(negedge clk);
        data0 = 8'hAA;
        @(negedge clk);
        data0 = 8'hBB;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (290) @(negedge clk);
        check("t5_queued", {29'd0, level0}, 32'd2);
        check("t5_bit3", {31'd0, tx0}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_tx", {31'd0, tx0}, 32'd1);
        check("t5_rst_busy", {31'd0, busy0}, 32'd0);
        check("t5_rst_level", {29'd0, level0}, 32'd0);
        check("t5_rst_ready", {31'd0, ready0}, 32'd1);
        hold_ok = 1'b1;
        repeat (800) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) hold_ok = 1'b0;
        end
        check("t5_no_frames", {31'd0, hold_ok}, 32'd1);

        // Simultaneous push and pop at the STOP-to-START edge.
        rxq0.delete(); rxs0.delete();
        data0 = 8'h11; valid0 = 1'b1;
        @(negedge clk);
        data0 = 8'h22;
        @(negedge clk);
        data0 = 8'h33;
        @(negedge clk);
        valid0 = 1'b0;
        check("t6_level_pre", {29'd0, level0}, 32'd2);
        repeat (688) @(negedge clk);
        check("t6_level_stop", {29'd0, level0}, 32'd2);
        check("t6_tx_stop", {31'd0, tx0}, 32'd1);
        data0 = 8'h44; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        check("t6_level_same", {29'd0, level0}, 32'd2);
        check("t6_tx_start", {31'd0, tx0}, 32'd0);
        check("t6_busy", {31'd0, busy0}, 32'd1);
        wait_rx0("t6_rx_count", 4, 4000);
        rx_expect("t6_rx0", 1'b0, 0, 8'h11);
        rx_expect("t6_rx1", 1'b0, 1, 8'h22);
        rx_expect("t6_rx2", 1'b0, 2, 8'h33);
        rx_expect("t6_rx3", 1'b0, 3, 8'h44);
        wait_idle("t6_idle_timeout", 1'b0, 1000);

        check("stop_bits_dut0", bad0, 32'd0);
        check("stop_bits_dut1", bad1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
